// File: rtl/sell_pkg.sv
// Shared types and constants for the ticket vending controller.
// The optional change output is enabled with the CHANGE_OUT_EN macro.
package sell_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam int DEF_UNIT_FARE = 5;
  localparam int DEF_MIN_HOPS  = 1;
  localparam int MONEY_W       = 6;
  localparam int SAT_LIMIT     = 63;
  // Wide enough for 63 * 15 * 7 before clamping
  localparam int FARE_W        = 14;

  function automatic logic [MONEY_W-1:0] sat_money(input logic [FARE_W-1:0] v);
    if (v > FARE_W'(SAT_LIMIT))
      return MONEY_W'(SAT_LIMIT);
    else
      return v[MONEY_W-1:0];
  endfunction

endpackage

// File: rtl/sell_fare_calc.sv
// Combinational fare: hop distance (with a minimum), times unit fare and
// ticket count, clamped to the 6-bit money range.
module sell_fare_calc
  import sell_pkg::*;
#(
  parameter int UNIT_FARE = DEF_UNIT_FARE,
  parameter int MIN_HOPS  = DEF_MIN_HOPS
) (
  input  logic [2:0]         origin,
  input  logic [2:0]         destination,
  input  logic [2:0]         tickets,
  output logic [MONEY_W-1:0] fare
);

  logic [2:0]        diff;
  logic [3:0]        hops;
  logic [FARE_W-1:0] product;

  always_comb begin
    diff    = (destination >= origin) ? (destination - origin) : (origin - destination);
    hops    = {1'b0, diff};
    if (hops < MIN_HOPS[3:0])
      hops = MIN_HOPS[3:0];
    product = FARE_W'(UNIT_FARE) * FARE_W'(hops) * FARE_W'(tickets);
    fare    = sat_money(product);
  end

endmodule

// File: rtl/sell.sv
// Ticket vending controller: latch a trip request, price it, then collect
// coins until the fare is covered. CHANGE_OUT_EN adds the changeOut port.
module sell
  import sell_pkg::*;
#(
  parameter int UNIT_FARE = DEF_UNIT_FARE,
  parameter int MIN_HOPS  = DEF_MIN_HOPS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         howManyTicket,
  input  logic [2:0]         origin,
  input  logic [2:0]         destination,
  input  logic [MONEY_W-1:0] money,
  output logic [MONEY_W-1:0] costOfticket,
  output logic [MONEY_W-1:0] moneyTopay,
  output logic [MONEY_W-1:0] totalMoney
`ifdef CHANGE_OUT_EN
  ,
  output logic [MONEY_W-1:0] changeOut
`endif
);

  state_t             state;
  logic [2:0]         orig_r;
  logic [2:0]         dest_r;
  logic [2:0]         tix_r;
  logic [MONEY_W-1:0] fare;
  logic [MONEY_W-1:0] new_total;

  sell_fare_calc #(
    .UNIT_FARE (UNIT_FARE),
    .MIN_HOPS  (MIN_HOPS)
  ) u_fare (
    .origin      (orig_r),
    .destination (dest_r),
    .tickets     (tix_r),
    .fare        (fare)
  );

  always_comb begin
    new_total = sat_money(FARE_W'({1'b0, totalMoney} + {1'b0, money}));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S0;
      orig_r       <= '0;
      dest_r       <= '0;
      tix_r        <= '0;
      costOfticket <= '0;
      moneyTopay   <= '0;
      totalMoney   <= '0;
`ifdef CHANGE_OUT_EN
      changeOut    <= '0;
`endif
    end else begin
      case (state)
        S0: begin
          orig_r       <= origin;
          dest_r       <= destination;
          tix_r        <= howManyTicket;
          costOfticket <= '0;
          moneyTopay   <= '0;
          totalMoney   <= '0;
`ifdef CHANGE_OUT_EN
          changeOut    <= '0;
`endif
          if (howManyTicket != 3'd0)
            state <= S1;
        end
        S1: begin
          costOfticket <= fare;
          moneyTopay   <= fare;
          totalMoney   <= '0;
`ifdef CHANGE_OUT_EN
          changeOut    <= '0;
`endif
          state        <= S2;
        end
        S2: begin
          // A zero coin value means no coin this cycle; everything holds
          if (money != '0) begin
            totalMoney <= new_total;
            if (new_total >= costOfticket) begin
              moneyTopay <= '0;
`ifdef CHANGE_OUT_EN
              changeOut  <= new_total - costOfticket;
`endif
              state      <= S3;
            end else begin
              moneyTopay <= costOfticket - new_total;
            end
          end
        end
        S3: begin
          state <= S3;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sell.sv
// Self-checking bench for sell: directed test-plan steps, then randomized
// trips, all compared against a behavioural model of the vending rules.
module tb_sell;

  localparam int UNIT_FARE = 5;
  localparam int MIN_HOPS  = 1;
  localparam int IDLE = 0, PRICE = 1, COLLECT = 2, DONE = 3;

  logic       clk;
  logic       reset;
  logic [2:0] howManyTicket;
  logic [2:0] origin;
  logic [2:0] destination;
  logic [5:0] money;
  logic [5:0] costOfticket;
  logic [5:0] moneyTopay;
  logic [5:0] totalMoney;
`ifdef CHANGE_OUT_EN
  logic [5:0] changeOut;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, plain integers
  int mPhase, mCost, mDue, mTotal, mChange, mOrig, mDest, mTix;

  sell dut (
    .clk           (clk),
    .reset         (reset),
    .howManyTicket (howManyTicket),
    .origin        (origin),
    .destination   (destination),
    .money         (money),
    .costOfticket  (costOfticket),
    .moneyTopay    (moneyTopay),
    .totalMoney    (totalMoney)
`ifdef CHANGE_OUT_EN
    ,
    .changeOut     (changeOut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tripFare(int o, int d, int t);
    int h;
    int f;
    h = (d > o) ? d - o : o - d;
    if (h < MIN_HOPS) h = MIN_HOPS;
    f = UNIT_FARE * h * t;
    return (f > 63) ? 63 : f;
  endfunction

  // Advance the model by one rising edge using the inputs seen at that edge
  task automatic modelStep(int r, int o, int d, int t, int m);
    if (r == 0) begin
      mPhase = IDLE; mCost = 0; mDue = 0; mTotal = 0; mChange = 0;
      mOrig = 0; mDest = 0; mTix = 0;
    end else if (mPhase == IDLE) begin
      mOrig = o; mDest = d; mTix = t;
      if (t != 0) mPhase = PRICE;
    end else if (mPhase == PRICE) begin
      mCost = tripFare(mOrig, mDest, mTix);
      mDue = mCost; mTotal = 0; mChange = 0;
      mPhase = COLLECT;
    end else if (mPhase == COLLECT && m != 0) begin
      mTotal = mTotal + m;
      if (mTotal > 63) mTotal = 63;
      if (mTotal >= mCost) begin
        mDue = 0; mChange = mTotal - mCost; mPhase = DONE;
      end else begin
        mDue = mCost - mTotal;
      end
    end
  endtask

  task automatic cmp(string tag, logic [7:0] obs, int exp);
    compared++;
    assert (obs === 8'(exp)) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    cmp({tag, ".state"}, {6'd0, dut.state}, mPhase);
    cmp({tag, ".costOfticket"}, {2'd0, costOfticket}, mCost);
    cmp({tag, ".moneyTopay"}, {2'd0, moneyTopay}, mDue);
    cmp({tag, ".totalMoney"}, {2'd0, totalMoney}, mTotal);
`ifdef CHANGE_OUT_EN
    cmp({tag, ".changeOut"}, {2'd0, changeOut}, mChange);
`endif
  endtask

  // Drive inputs after the falling edge, clock once, then check at the next falling edge
  task automatic applyStimulus(string tag, int r, int o, int d, int t, int m);
    reset = r[0]; origin = o[2:0]; destination = d[2:0];
    howManyTicket = t[2:0]; money = m[5:0];
    @(posedge clk);
    modelStep(r, o, d, t, m);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b0; origin = '0; destination = '0; howManyTicket = '0; money = '0;
    mPhase = IDLE; mCost = 0; mDue = 0; mTotal = 0; mChange = 0;
    mOrig = 0; mDest = 0; mTix = 0;
    @(negedge clk);

    // Reset, then a 1->2 trip for two tickets paid with two coins of 5
    applyStimulus("rst_hold", 0, 1, 2, 2, 0);
    applyStimulus("req_sample", 1, 1, 2, 2, 0);
    applyStimulus("price_10", 1, 1, 2, 2, 0);
    applyStimulus("coin5_a", 1, 1, 2, 2, 5);
    applyStimulus("coin5_b", 1, 1, 2, 2, 5);
    applyStimulus("done_ignore50", 1, 1, 2, 2, 50);
    applyStimulus("rst_after_done", 0, 1, 2, 2, 0);

    // Overpay 50 on a fare of 15
    applyStimulus("op_req", 1, 3, 0, 1, 0);
    applyStimulus("op_price", 1, 3, 0, 1, 0);
    applyStimulus("op_coin50", 1, 3, 0, 1, 50);
    applyStimulus("op_rst", 0, 0, 0, 0, 0);

    // Fare and total both clamp at 63
    applyStimulus("sat_req", 1, 0, 7, 7, 0);
    applyStimulus("sat_price", 1, 0, 7, 7, 0);
    applyStimulus("sat_coin_a", 1, 0, 7, 7, 50);
    applyStimulus("sat_coin_b", 1, 0, 7, 7, 50);
    applyStimulus("sat_rst", 0, 0, 0, 0, 0);

    // Zero-distance trip charges the minimum hop; idle cycles and input changes hold
    applyStimulus("zd_req", 1, 4, 4, 3, 0);
    applyStimulus("zd_price", 1, 4, 4, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus("zd_nocoin", 1, 4, 4, 3, 0);
    applyStimulus("chg_inputs", 1, 7, 0, 5, 0);
    applyStimulus("chg_coin7", 1, 1, 6, 2, 7);
    applyStimulus("chg_coin20", 1, 2, 3, 7, 20);
    applyStimulus("zd_rst", 0, 0, 0, 0, 0);

    // No request keeps the controller idle even with coins
    for (int i = 0; i < 5; i++) applyStimulus("noreq", 1, 2, 5, 0, 10);

    // Randomized trips with occasional mid-flight resets
    for (int trip = 0; trip < 40; trip++) begin
      int o, d, t;
      o = $urandom_range(0, 7);
      d = $urandom_range(0, 7);
      t = $urandom_range(0, 7);
      for (int c = 0; c < 12; c++) begin
        int r, m;
        r = ($urandom_range(0, 19) == 0) ? 0 : 1;
        m = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
        if (c > 2) begin
          o = $urandom_range(0, 7);
          d = $urandom_range(0, 7);
          t = $urandom_range(0, 7);
        end
        applyStimulus("rand", r, o, d, t, m);
      end
      applyStimulus("rand_rst", 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
